// File: rtl/regfile_preload_ctrl.sv
// Preload sequencer: streams (channel, address, data) words into the regfile
// write ports, then starts the datapath after a settle delay.
//
// state  | meaning
// IDLE   | waiting for go; no words accepted
// LOAD   | accepting config words, one registered strobe per word
// SETTLE | last word accepted; counting down before start
// RUN    | is_start held high until abort
module regfile_preload_ctrl #(
    parameter int NUM_CH     = 2,
    parameter int CH_W       = 1,
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int SETTLE_CYC = 3,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go,
    input  logic              abort,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              cfg_last,
    output logic [NUM_CH-1:0] ran_we,
    output logic [ADDR_W-1:0] ran_w_addr,
    output logic [DATA_W-1:0] ran_w_data,
    output logic              is_start,
    output logic              busy,
    output logic              err_ch,
    output logic [CNT_W-1:0]  wr_count
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_RUN    = 2'd3;

    localparam int              SET_W    = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);
    localparam logic [CH_W:0]   CH_LIMIT = (CH_W + 1)'(NUM_CH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]        state;
    logic [SET_W-1:0]  settle_cnt;
    logic              accept;
    logic              ch_ok;
    logic              issue;
    logic              open_session;
    logic [NUM_CH-1:0] we_sel;

    assign cfg_ready    = (state == ST_LOAD);
    assign accept       = cfg_valid && cfg_ready;
    assign ch_ok        = ({1'b0, cfg_ch} < CH_LIMIT);
    // abort in the accept cycle cancels the write before it is registered
    assign issue        = accept && ch_ok && !abort;
    assign open_session = (state == ST_IDLE) && go && !abort;

    assign is_start = (state == ST_RUN);
    assign busy     = (state == ST_LOAD) || (state == ST_SETTLE);

    always_comb begin
        we_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            we_sel[i] = (cfg_ch == CH_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
        end else if (abort) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (go) state <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (accept && cfg_last) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= SET_W'(SETTLE_CYC);
                    end
                end
                ST_SETTLE: begin
                    // terminal count at 1 gives SETTLE_CYC cycles in SETTLE
                    if (settle_cnt == SET_W'(1)) state <= ST_RUN;
                    else settle_cnt <= settle_cnt - SET_W'(1);
                end
                ST_RUN: ;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ran_we     <= '0;
            ran_w_addr <= '0;
            ran_w_data <= '0;
        end else begin
            ran_we <= issue ? we_sel : '0;
            if (issue) begin
                ran_w_addr <= cfg_addr;
                ran_w_data <= cfg_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count <= '0;
            err_ch   <= 1'b0;
        end else if (open_session) begin
            wr_count <= '0;
            err_ch   <= 1'b0;
        end else begin
            if (issue && (wr_count != CNT_MAX)) wr_count <= wr_count + CNT_W'(1);
            if (accept && !ch_ok && !abort) err_ch <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_preload_ctrl.sv
// Directed bench for regfile_preload_ctrl; a second single-channel instance
// shares the stimulus to exercise out-of-range channel handling.
module tb_regfile_preload_ctrl;

    logic        clk;
    logic        rst_n;
    logic        go;
    logic        abort;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [0:0]  cfg_ch;
    logic [11:0] cfg_addr;
    logic [31:0] cfg_data;
    logic        cfg_last;
    logic [1:0]  ran_we;
    logic [11:0] ran_w_addr;
    logic [31:0] ran_w_data;
    logic        is_start;
    logic        busy;
    logic        err_ch;
    logic [15:0] wr_count;

    logic        cfg_ready1;
    logic [0:0]  ran_we1;
    logic [11:0] ran_w_addr1;
    logic [31:0] ran_w_data1;
    logic        is_start1;
    logic        busy1;
    logic        err_ch1;
    logic [15:0] wr_count1;

    int n_cmp = 0;
    int n_err = 0;

    regfile_preload_ctrl dut (
        .clk(clk), .rst_n(rst_n), .go(go), .abort(abort),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_last(cfg_last),
        .ran_we(ran_we), .ran_w_addr(ran_w_addr), .ran_w_data(ran_w_data),
        .is_start(is_start), .busy(busy), .err_ch(err_ch), .wr_count(wr_count)
    );

    regfile_preload_ctrl #(.NUM_CH(1), .CH_W(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .go(go), .abort(abort),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready1), .cfg_ch(cfg_ch),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_last(cfg_last),
        .ran_we(ran_we1), .ran_w_addr(ran_w_addr1), .ran_w_data(ran_w_data1),
        .is_start(is_start1), .busy(busy1), .err_ch(err_ch1), .wr_count(wr_count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic word(input logic [0:0] ch, input logic [11:0] a, input logic [31:0] d,
                        input logic last);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_addr  = a;
        cfg_data  = d;
        cfg_last  = last;
    endtask

    initial begin
        rst_n = 1'b0; go = 1'b0; abort = 1'b0;
        cfg_valid = 1'b0; cfg_ch = '0; cfg_addr = '0; cfg_data = '0; cfg_last = 1'b0;
        step(); step();
        chk("rst_ready", cfg_ready, 0);
        chk("rst_we", ran_we, 0);
        chk("rst_addr", ran_w_addr, 0);
        chk("rst_data", ran_w_data, 0);
        chk("rst_start", is_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_ch, 0);
        chk("rst_cnt", wr_count, 0);
        rst_n = 1'b1;
        step();

        // session 1: ch1 then ch0 with last
        go = 1'b1; step(); go = 1'b0;
        chk("s1_ready", cfg_ready, 1);
        chk("s1_busy", busy, 1);
        word(1'b1, 12'd0, 32'h0, 1'b0);
        step();
        chk("s1_we_a", ran_we, 2'b10);
        chk("s1_data_a", ran_w_data, 32'h0);
        word(1'b0, 12'd0, 32'h02010006, 1'b1);
        step();
        cfg_valid = 1'b0; cfg_last = 1'b0;
        chk("s1_we_b", ran_we, 2'b01);
        chk("s1_data_b", ran_w_data, 32'h02010006);
        chk("s1_cnt", wr_count, 2);
        chk("s1_ready_settle", cfg_ready, 0);
        step();
        chk("s1_we_idle", ran_we, 0);
        chk("s1_start_p1", is_start, 0);
        step();
        chk("s1_start_p2", is_start, 0);
        chk("s1_busy_p2", busy, 1);
        step();
        chk("s1_start_p3", is_start, 1);
        chk("s1_busy_run", busy, 0);
        go = 1'b1; step(); go = 1'b0;
        chk("run_go_start", is_start, 1);
        chk("run_go_cnt", wr_count, 2);
        abort = 1'b1; step(); abort = 1'b0;
        chk("abort_start", is_start, 0);
        chk("abort_cnt", wr_count, 2);

        // session 2: four back-to-back ch0 words
        go = 1'b1; step(); go = 1'b0;
        chk("s2_cnt_clr", wr_count, 0);
        for (int i = 0; i < 4; i++) begin
            word(1'b0, 12'(i), 32'h100 + 32'(i), (i == 3));
            step();
            chk("s2_we", ran_we, 2'b01);
            chk("s2_addr", ran_w_addr, i);
            chk("s2_data", ran_w_data, 32'h100 + i);
        end
        cfg_valid = 1'b0; cfg_last = 1'b0;
        chk("s2_cnt", wr_count, 4);
        step(); step();
        chk("s2_busy_settle", busy, 1);
        step();
        chk("s2_start", is_start, 1);
        chk("s2_busy_run", busy, 0);
        abort = 1'b1; step(); abort = 1'b0;

        // session 3: out-of-range channel on the single-channel instance, then abort in SETTLE
        go = 1'b1; step(); go = 1'b0;
        word(1'b1, 12'd5, 32'hAAAA, 1'b0);
        step();
        chk("s3_we1_none", ran_we1, 0);
        chk("s3_err1", err_ch1, 1);
        chk("s3_cnt1", wr_count1, 0);
        chk("s3_we_main", ran_we, 2'b10);
        chk("s3_err_main", err_ch, 0);
        word(1'b0, 12'd6, 32'h55, 1'b1);
        step();
        cfg_valid = 1'b0; cfg_last = 1'b0;
        chk("s3_we1", ran_we1, 1);
        chk("s3_addr1", ran_w_addr1, 6);
        chk("s3_cnt1_b", wr_count1, 1);
        abort = 1'b1; step(); abort = 1'b0;
        chk("s3_abort_start", is_start, 0);
        chk("s3_abort_busy", busy, 0);
        chk("s3_abort_cnt", wr_count, 2);
        chk("s3_abort_err1", err_ch1, 1);
        step(); step(); step();
        chk("s3_never_start", is_start, 0);

        // cfg_valid in IDLE, then go+abort together
        word(1'b0, 12'd9, 32'h99, 1'b0);
        step();
        chk("idle_valid_we", ran_we, 0);
        cfg_valid = 1'b0;
        go = 1'b1; abort = 1'b1; step(); go = 1'b0; abort = 1'b0;
        chk("goabort_busy", busy, 0);
        chk("goabort_cnt", wr_count, 2);

        // session 4: abort in accept cycle cancels write; then stall gap
        go = 1'b1; step(); go = 1'b0;
        chk("s4_cnt_clr", wr_count, 0);
        chk("s4_err1_clr", err_ch1, 0);
        word(1'b0, 12'd1, 32'h11, 1'b0);
        abort = 1'b1; step(); abort = 1'b0;
        cfg_valid = 1'b0;
        chk("s4_abort_we", ran_we, 0);
        chk("s4_abort_cnt", wr_count, 0);
        go = 1'b1; step(); go = 1'b0;
        word(1'b0, 12'd1, 32'h11, 1'b0);
        step();
        cfg_valid = 1'b0;
        chk("s4_we_a", ran_we, 2'b01);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_we", ran_we, 0);
            chk("stall_ready", cfg_ready, 1);
        end
        word(1'b1, 12'd2, 32'h22, 1'b1);
        step();
        cfg_valid = 1'b0; cfg_last = 1'b0;
        chk("s4_we_b", ran_we, 2'b10);
        chk("s4_addr_b", ran_w_addr, 2);
        chk("s4_cnt", wr_count, 2);
        step(); step(); step();
        chk("s4_start", is_start, 1);
        step();
        chk("s4_hold_addr", ran_w_addr, 2);
        abort = 1'b1; step(); abort = 1'b0;

        // reset mid-LOAD with cfg_valid held high
        go = 1'b1; step(); go = 1'b0;
        word(1'b0, 12'd7, 32'h77, 1'b0);
        step();
        chk("s5_we", ran_we, 2'b01);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_we", ran_we, 0);
        chk("mrst_addr", ran_w_addr, 0);
        chk("mrst_data", ran_w_data, 0);
        chk("mrst_cnt", wr_count, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_ready", cfg_ready, 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_we", ran_we, 0);
            chk("post_rst_busy", busy, 0);
            chk("post_rst_ready", cfg_ready, 0);
        end
        cfg_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
